zero_skip_packer: RTL and testbench
===================================

Name: zero_skip_packer

Overview:
- Upstream neighbour of the flash router's multi-input single-output FIFO.
- Accepts one activation window of DATA_LENGTH words per handshake and drops the zero words.
- Packs the nonzero words contiguously from slot 0 and emits a thermometer valid mask, so the FIFO write always lands in consecutive entries.
- Two-stage pipeline. Stalls on FIFO full; never drops a window.

Parameters:
- DATA_WIDTH, 8: bits per activation word.
- DATA_LENGTH, 9: words per window (3x3 kernel).
- CNT_WIDTH, $clog2(DATA_LENGTH+1): width of the per-window nonzero count.
- STAT_WIDTH, 32: width of the running statistics counters.

Ports:
- i_clk  in  1  clock.
- i_nrst  in  1  reset, asynchronous, active-low.
- i_clear  in  1  synchronous flush of pipeline and statistics.
- i_valid  in  1  input window valid.
- o_ready  out  1  packer can accept a window this cycle.
- i_data  in  [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  input window, index 0 first.
- i_fifo_full  in  1  downstream FIFO full.
- o_write_en  out  1  write strobe to the FIFO.
- o_data  out  [0:DATA_LENGTH-1][DATA_WIDTH-1:0]  packed window.
- o_valid  out  DATA_LENGTH  thermometer mask of occupied slots.
- o_count  out  CNT_WIDTH  nonzero words in the presented window.
- o_win_total  out  STAT_WIDTH  windows accepted since reset/clear.
- o_nz_total  out  STAT_WIDTH  nonzero words written since reset/clear.
- o_busy  out  1  either pipeline stage holds a window.

Behaviour:
- Reset (i_nrst low, asynchronous):
  - s1_valid, s2_valid, all data/mask/count registers and both totals go to 0.
  - Hence o_write_en=0, o_data=0, o_valid=0, o_count=0, o_busy=0.
  - o_ready is 1 once reset is released.
- i_clear (synchronous):
  - Same effect as reset at the clock edge.
  - Has priority over accept and write; a window presented in a clear cycle is discarded.
  - o_write_en is forced to 0 during the clear cycle.
- Stage S1 (capture):
  - On accept (i_valid & o_ready), register i_data and nz_mask[i] = (i_data[i] != 0); set s1_valid.
- Stage S2 (pack):
  - Output slot j holds the j-th nonzero word of the S1 window, in index order. Slots at and above count are 0.
  - count = popcount(nz_mask).
  - o_valid = (1<<count)-1.
- Output:
  - o_data, o_valid and o_count drive directly from the S2 registers.
  - o_write_en = s2_valid & (count != 0) & ~i_fifo_full.
- Advance rules:
  - s2_free = ~s2_valid | ~i_fifo_full.
  - S1 moves to S2 when s1_valid & s2_free.
  - o_ready = ~s1_valid | s2_free (combinational; it is fine for this to depend on i_fifo_full).
- Consume:
  - S2 is consumed when s2_valid & ~i_fifo_full.
  - An all-zero window (count=0) is consumed in one cycle with no write, and still advances o_win_total.
- Latency:
  - A window accepted at edge k presents on the outputs after edge k+1.
  - With i_fifo_full low, o_write_en is high in the cycle between edges k+1 and k+2.
  - Throughput is 1 window/cycle.
- Stall: while i_fifo_full=1, the S2 contents and o_data/o_valid/o_count are held stable. S1 fills, then o_ready drops.
- Simultaneous accept and drain in one cycle is allowed and must not lose or duplicate a window.
- Statistics:
  - o_win_total += 1 per accept.
  - o_nz_total += count per o_write_en.
  - Both wrap modulo 2^STAT_WIDTH.
- Reset or clear mid-stall discards both in-flight windows. No partial write is issued.

Decomposition:
- Shared package router_pkg:
  - DATA_WIDTH/DATA_LENGTH defaults.
  - Typedef for the window array [0:DATA_LENGTH-1][DATA_WIDTH-1:0].
  - Function thermometer(count).
- Sub-module zero_compactor: purely combinational prefix-sum compaction. Takes window and nz_mask; returns packed window and count. Instantiated once between S1 and S2.

Test Plan (all with DATA_LENGTH=9, DATA_WIDTH=8):
- Dense window: window {1..9}, fifo not full -> o_write_en two cycles later, o_data={1..9}, o_valid=9'h1FF, o_count=9; o_nz_total=9.
- Sparse window: {0,5,0,0,7,0,0,0,3} -> o_data={5,7,3,0,0,0,0,0,0}, o_valid=9'h007, o_count=3.
- All-zero window: all zero -> no o_write_en pulse; o_win_total increments by 1, o_nz_total unchanged.
- Back-pressure: hold i_fifo_full=1 with 3 back-to-back windows -> o_ready drops after 2 accepts and o_data stays stable. Release full -> the 2 windows write on consecutive cycles, in order, and the third is then accepted.
- Streaming: 20 random windows, fifo never full -> 20 accepts, the nonzero windows appear 1/cycle, and o_nz_total equals the reference popcount sum.
- Clear/reset mid-stall: pipeline full, i_fifo_full=1, pulse i_clear -> next cycle o_busy=0, o_write_en=0, both totals 0, o_ready=1. Repeat with asynchronous i_nrst asserted mid-cycle -> same outcome immediately.

Source files
------------

// File: rtl/router_pkg.sv
// Shared definitions for the flash router datapath: window geometry defaults,
// the window array type and the thermometer-mask helper.
package router_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned DEF_DATA_LENGTH = 9;
  localparam int unsigned DEF_CNT_WIDTH   = $clog2(DEF_DATA_LENGTH + 1);
  localparam int unsigned THERMO_WIDTH    = 64;

  typedef logic [0:DEF_DATA_LENGTH-1][DEF_DATA_WIDTH-1:0] window_t;

  // Returns (1 << count) - 1; callers slice off the lanes they use.
  function automatic logic [THERMO_WIDTH-1:0] thermometer(input int unsigned count);
    logic [THERMO_WIDTH-1:0] mask;
    for (int unsigned i = 0; i < THERMO_WIDTH; i++) begin
      mask[i] = (i < count);
    end
    return mask;
  endfunction

endpackage

// File: rtl/zero_compactor.sv
// Combinational compaction: moves the flagged words of a window to the low
// slots in index order and zero-fills the rest.
module zero_compactor #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DATA_LENGTH = 9,
  parameter int unsigned CNT_WIDTH   = $clog2(DATA_LENGTH + 1)
) (
  input  logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] window_i,
  input  logic [DATA_LENGTH-1:0]                 nz_mask_i,
  output logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] packed_o,
  output logic [CNT_WIDTH-1:0]                   count_o
);

  // Running prefix sum of the mask gives each kept word its output slot.
  always_comb begin
    logic [CNT_WIDTH-1:0] pos;
    packed_o = '0;
    pos      = '0;
    for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
      if (nz_mask_i[i]) begin
        packed_o[pos] = window_i[i];
        pos           = pos + CNT_WIDTH'(1);
      end
    end
    count_o = pos;
  end

endmodule

// File: rtl/zero_skip_packer.sv
// Two-stage packer in front of the router FIFO: drops zero activations and
// presents the survivors contiguously from slot 0 with a thermometer mask.
module zero_skip_packer
  import router_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
  parameter int unsigned CNT_WIDTH   = $clog2(DATA_LENGTH + 1),
  parameter int unsigned STAT_WIDTH  = 32
) (
  input  logic                                   i_clk,
  input  logic                                   i_nrst,
  input  logic                                   i_clear,
  input  logic                                   i_valid,
  output logic                                   o_ready,
  input  logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] i_data,
  input  logic                                   i_fifo_full,
  output logic                                   o_write_en,
  output logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] o_data,
  output logic [DATA_LENGTH-1:0]                 o_valid,
  output logic [CNT_WIDTH-1:0]                   o_count,
  output logic [STAT_WIDTH-1:0]                  o_win_total,
  output logic [STAT_WIDTH-1:0]                  o_nz_total,
  output logic                                   o_busy
);

  typedef logic [0:DATA_LENGTH-1][DATA_WIDTH-1:0] win_t;

  logic                  s1_valid_q, s1_valid_d;
  win_t                  s1_data_q, s1_data_d;
  logic [DATA_LENGTH-1:0] s1_nz_q, s1_nz_d;

  logic                  s2_valid_q, s2_valid_d;
  win_t                  s2_data_q, s2_data_d;
  logic [DATA_LENGTH-1:0] s2_mask_q, s2_mask_d;
  logic [CNT_WIDTH-1:0]  s2_count_q, s2_count_d;

  logic [STAT_WIDTH-1:0] win_total_q, win_total_d;
  logic [STAT_WIDTH-1:0] nz_total_q, nz_total_d;

  logic                  s2_free, accept, s1_adv, s2_consume, write_en;
  win_t                  pack_data;
  logic [CNT_WIDTH-1:0]  pack_count;
  logic [THERMO_WIDTH-1:0] thermo_full;
  logic [DATA_LENGTH-1:0]  pack_mask;
  logic                  unused_thermo;

  zero_compactor #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DATA_LENGTH (DATA_LENGTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_compactor (
    .window_i  (s1_data_q),
    .nz_mask_i (s1_nz_q),
    .packed_o  (pack_data),
    .count_o   (pack_count)
  );

  always_comb begin
    thermo_full   = thermometer(32'(pack_count));
    pack_mask     = thermo_full[DATA_LENGTH-1:0];
    unused_thermo = ^thermo_full[THERMO_WIDTH-1:DATA_LENGTH];
  end

  // Handshake and advance conditions; clear overrides every transfer.
  always_comb begin
    s2_free    = ~s2_valid_q | ~i_fifo_full;
    o_ready    = ~s1_valid_q | s2_free;
    accept     = i_valid & o_ready & ~i_clear;
    s1_adv     = s1_valid_q & s2_free & ~i_clear;
    s2_consume = s2_valid_q & ~i_fifo_full & ~i_clear;
    write_en   = s2_consume & (s2_count_q != '0);
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_nz_d     = s1_nz_q;
    s2_valid_d  = s2_valid_q;
    s2_data_d   = s2_data_q;
    s2_mask_d   = s2_mask_q;
    s2_count_d  = s2_count_q;
    win_total_d = win_total_q;
    nz_total_d  = nz_total_q;

    if (i_clear) begin
      s1_valid_d  = 1'b0;
      s1_data_d   = '0;
      s1_nz_d     = '0;
      s2_valid_d  = 1'b0;
      s2_data_d   = '0;
      s2_mask_d   = '0;
      s2_count_d  = '0;
      win_total_d = '0;
      nz_total_d  = '0;
    end else begin
      if (accept) begin
        s1_valid_d = 1'b1;
        s1_data_d  = i_data;
        for (int unsigned i = 0; i < DATA_LENGTH; i++) begin
          s1_nz_d[i] = (i_data[i] != '0);
        end
        win_total_d = win_total_q + STAT_WIDTH'(1);
      end else if (s1_adv) begin
        s1_valid_d = 1'b0;
      end

      // Refill takes precedence over drain so a same-cycle hand-off is seamless.
      if (s1_adv) begin
        s2_valid_d = 1'b1;
        s2_data_d  = pack_data;
        s2_mask_d  = pack_mask;
        s2_count_d = pack_count;
      end else if (s2_consume) begin
        s2_valid_d = 1'b0;
      end

      if (write_en) begin
        nz_total_d = nz_total_q + STAT_WIDTH'(s2_count_q);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_nz_q     <= '0;
      s2_valid_q  <= 1'b0;
      s2_data_q   <= '0;
      s2_mask_q   <= '0;
      s2_count_q  <= '0;
      win_total_q <= '0;
      nz_total_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_nz_q     <= s1_nz_d;
      s2_valid_q  <= s2_valid_d;
      s2_data_q   <= s2_data_d;
      s2_mask_q   <= s2_mask_d;
      s2_count_q  <= s2_count_d;
      win_total_q <= win_total_d;
      nz_total_q  <= nz_total_d;
    end
  end

  always_comb begin
    o_write_en  = write_en;
    o_data      = s2_data_q;
    o_valid     = s2_mask_q;
    o_count     = s2_count_q;
    o_win_total = win_total_q;
    o_nz_total  = nz_total_q;
    o_busy      = s1_valid_q | s2_valid_q;
  end

endmodule

// File: tb/tb_zero_skip_packer.sv
// Directed bench for zero_skip_packer: vector table, back-pressure, streaming,
// and clear/reset while stalled.
module tb_zero_skip_packer;
  import router_pkg::*;

  logic          clk = 1'b0;
  logic          nrst;
  logic          clear;
  logic          valid;
  logic          ready;
  window_t       data_in;
  logic          fifo_full;
  logic          write_en;
  window_t       data_out;
  logic [8:0]    valid_out;
  logic [3:0]    count_out;
  logic [31:0]   win_total;
  logic [31:0]   nz_total;
  logic          busy;

  int n_assert = 0;
  int n_fail   = 0;

  zero_skip_packer #(
    .DATA_WIDTH  (8),
    .DATA_LENGTH (9),
    .CNT_WIDTH   (4),
    .STAT_WIDTH  (32)
  ) dut (
    .i_clk       (clk),
    .i_nrst      (nrst),
    .i_clear     (clear),
    .i_valid     (valid),
    .o_ready     (ready),
    .i_data      (data_in),
    .i_fifo_full (fifo_full),
    .o_write_en  (write_en),
    .o_data      (data_out),
    .o_valid     (valid_out),
    .o_count     (count_out),
    .o_win_total (win_total),
    .o_nz_total  (nz_total),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    window_t    din;
    window_t    exp_data;
    logic [8:0] exp_mask;
    logic [3:0] exp_count;
  } vec_t;

  typedef struct {
    window_t    pdata;
    logic [3:0] cnt;
  } exp_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  vec_t    vecs[8];
  exp_t    expq[$];
  exp_t    e;
  window_t win_a, win_b, win_c, pa, pb, pc, w;
  int      exp_win, exp_nz, accepts, writes, exp_writes;
  logic [3:0] cnt;

  initial begin
    vecs[0] = '{{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9},
                {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 9'h1FF, 4'd9};
    vecs[1] = '{{8'd0, 8'd5, 8'd0, 8'd0, 8'd7, 8'd0, 8'd0, 8'd0, 8'd3},
                {8'd5, 8'd7, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 9'h007, 4'd3};
    vecs[2] = '{'0, '0, 9'h000, 4'd0};
    vecs[3] = '{{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hAA},
                {8'hAA, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 9'h001, 4'd1};
    vecs[4] = '{{8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0},
                {8'h80, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 9'h001, 4'd1};
    vecs[5] = '{{8'd0, 8'd1, 8'd0, 8'd2, 8'd0, 8'd3, 8'd0, 8'd4, 8'd0},
                {8'd1, 8'd2, 8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0}, 9'h00F, 4'd4};
    vecs[6] = '{{9{8'hFF}}, {9{8'hFF}}, 9'h1FF, 4'd9};
    vecs[7] = '{{8'hFF, 8'd0, 8'hFE, 8'hFD, 8'd0, 8'hFC, 8'hFB, 8'hFA, 8'd0},
                {8'hFF, 8'hFE, 8'hFD, 8'hFC, 8'hFB, 8'hFA, 8'd0, 8'd0, 8'd0}, 9'h03F, 4'd6};

    nrst = 1'b0; clear = 1'b0; valid = 1'b0; data_in = '0; fifo_full = 1'b0;
    #12;
    chk("reset_write_en", 128'(write_en), 128'(1'b0));
    chk("reset_busy", 128'(busy), 128'(1'b0));
    chk("reset_data", 128'(data_out), 128'(0));
    chk("reset_valid", 128'(valid_out), 128'(0));
    nrst = 1'b1;
    tick();
    chk("reset_ready", 128'(ready), 128'(1'b1));
    chk("reset_win_total", 128'(win_total), 128'(0));

    // Table-driven single windows, one at a time with the FIFO open.
    exp_win = 0; exp_nz = 0;
    foreach (vecs[v]) begin
      valid = 1'b1; data_in = vecs[v].din;
      tick();
      valid = 1'b0; data_in = '0;
      exp_win++;
      tick();
      @(negedge clk);
      chk($sformatf("v%0d_write_en", v), 128'(write_en), 128'(vecs[v].exp_count != 0));
      chk($sformatf("v%0d_data", v), 128'(data_out), 128'(vecs[v].exp_data));
      chk($sformatf("v%0d_mask", v), 128'(valid_out), 128'(vecs[v].exp_mask));
      chk($sformatf("v%0d_count", v), 128'(count_out), 128'(vecs[v].exp_count));
      chk($sformatf("v%0d_win_total", v), 128'(win_total), 128'(exp_win));
      tick();
      exp_nz += int'(vecs[v].exp_count);
      chk($sformatf("v%0d_nz_total", v), 128'(nz_total), 128'(exp_nz));
    end

    // Back-pressure: two windows fill the pipe, third waits for release.
    win_a = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
    pa    = {8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    win_b = {8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    pb    = {8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    win_c = {8'd4, 8'd0, 8'd5, 8'd0, 8'd6, 8'd0, 8'd7, 8'd0, 8'd0};
    pc    = {8'd4, 8'd5, 8'd6, 8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    fifo_full = 1'b1; valid = 1'b1; data_in = win_a;
    tick();
    data_in = win_b;
    @(negedge clk);
    chk("bp_ready_after_1", 128'(ready), 128'(1'b1));
    tick();
    data_in = win_c;
    @(negedge clk);
    chk("bp_ready_after_2", 128'(ready), 128'(1'b0));
    chk("bp_no_write", 128'(write_en), 128'(1'b0));
    chk("bp_data_a", 128'(data_out), 128'(pa));
    tick(); tick();
    @(negedge clk);
    chk("bp_data_stable", 128'(data_out), 128'(pa));
    chk("bp_count_stable", 128'(count_out), 128'(4'd2));
    chk("bp_ready_held", 128'(ready), 128'(1'b0));
    chk("bp_win_total", 128'(win_total), 128'(exp_win + 2));
    tick();
    fifo_full = 1'b0;
    @(negedge clk);
    chk("bp_rel_write_a", 128'(write_en), 128'(1'b1));
    chk("bp_rel_data_a", 128'(data_out), 128'(pa));
    chk("bp_rel_ready", 128'(ready), 128'(1'b1));
    tick();
    valid = 1'b0; data_in = '0;
    @(negedge clk);
    chk("bp_write_b", 128'(write_en), 128'(1'b1));
    chk("bp_data_b", 128'(data_out), 128'(pb));
    tick();
    @(negedge clk);
    chk("bp_write_c", 128'(write_en), 128'(1'b1));
    chk("bp_data_c", 128'(data_out), 128'(pc));
    chk("bp_win_total_3", 128'(win_total), 128'(exp_win + 3));
    tick(); tick();
    chk("bp_nz_total", 128'(nz_total), 128'(exp_nz + 2 + 1 + 4));
    chk("bp_idle", 128'(busy), 128'(1'b0));

    // Streaming 20 random windows back to back after a clear.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_win_total", 128'(win_total), 128'(0));
    chk("clr_nz_total", 128'(nz_total), 128'(0));
    exp_nz = 0; exp_writes = 0; accepts = 0; writes = 0;
    for (int c = 0; c < 24; c++) begin
      if (c < 20) begin
        w = '0;
        if ($urandom_range(0, 4) != 0) begin
          for (int i = 0; i < 9; i++) begin
            if ($urandom_range(0, 2) != 0) w[i] = 8'($urandom_range(1, 255));
          end
        end
        e.pdata = '0; cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
          if (w[i] != 8'd0) begin
            e.pdata[cnt] = w[i];
            cnt = cnt + 4'd1;
          end
        end
        e.cnt = cnt;
        if (cnt != 4'd0) begin
          expq.push_back(e);
          exp_writes++;
        end
        exp_nz += int'(cnt);
        valid = 1'b1; data_in = w;
      end else begin
        valid = 1'b0; data_in = '0;
      end
      @(negedge clk);
      if (valid && ready) accepts++;
      if (write_en) begin
        writes++;
        if (expq.size() == 0) begin
          chk("stream_unexpected_write", 128'(write_en), 128'(1'b0));
        end else begin
          e = expq.pop_front();
          chk($sformatf("stream_data_%0d", writes), 128'(data_out), 128'(e.pdata));
          chk($sformatf("stream_count_%0d", writes), 128'(count_out), 128'(e.cnt));
        end
      end
      tick();
    end
    chk("stream_accepts", 128'(accepts), 128'(20));
    chk("stream_writes", 128'(writes), 128'(exp_writes));
    chk("stream_win_total", 128'(win_total), 128'(20));
    chk("stream_nz_total", 128'(nz_total), 128'(exp_nz));

    // Clear while stalled with both stages occupied.
    fifo_full = 1'b1; valid = 1'b1; data_in = win_a;
    tick();
    data_in = win_b;
    tick();
    data_in = win_c; clear = 1'b1; fifo_full = 1'b0;
    @(negedge clk);
    chk("clr_cycle_no_write", 128'(write_en), 128'(1'b0));
    tick();
    clear = 1'b0; valid = 1'b0; fifo_full = 1'b1;
    @(negedge clk);
    chk("clr_busy", 128'(busy), 128'(1'b0));
    chk("clr_write_en", 128'(write_en), 128'(1'b0));
    chk("clr_win_zero", 128'(win_total), 128'(0));
    chk("clr_nz_zero", 128'(nz_total), 128'(0));
    chk("clr_ready", 128'(ready), 128'(1'b1));
    chk("clr_count", 128'(count_out), 128'(0));

    // Asynchronous reset while stalled.
    tick();
    valid = 1'b1; data_in = win_a;
    tick();
    data_in = win_b;
    tick();
    valid = 1'b0; data_in = '0;
    @(negedge clk);
    chk("rst_pre_busy", 128'(busy), 128'(1'b1));
    nrst = 1'b0; fifo_full = 1'b0;
    #1;
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_write_en", 128'(write_en), 128'(1'b0));
    chk("rst_data", 128'(data_out), 128'(0));
    chk("rst_valid", 128'(valid_out), 128'(0));
    chk("rst_win_total", 128'(win_total), 128'(0));
    chk("rst_nz_total", 128'(nz_total), 128'(0));
    #1;
    nrst = 1'b1;
    tick();
    chk("rst_ready", 128'(ready), 128'(1'b1));
    chk("rst_idle", 128'(busy), 128'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
